// File: rtl/pipelined_adder_n.sv
// pipelined_adder_n: valid/ready pipelined add/subtract, one ripple-carry chunk per stage
module pipelined_adder_n #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int CHUNK = WIDTH / STAGES;
  logic adv;
  logic ovf_q;
  logic zero_q;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i, b_i, s_i, s_n, a_q, b_q, s_q;
    logic v_i, c_i, c_n, v_q, c_q;
    logic [CHUNK-1:0] r;
    logic unused_bits;
    if (k == 0) begin : g_first
      assign a_i = A;
      assign b_i = sub ? ~B : B;
      assign s_i = '0;
      assign c_i = sub ? ~cin : cin;
      assign v_i = in_valid;
    end else begin : g_next
      assign a_i = g_stage[k-1].a_q;
      assign b_i = g_stage[k-1].b_q;
      assign s_i = g_stage[k-1].s_q;
      assign c_i = g_stage[k-1].c_q;
      assign v_i = g_stage[k-1].v_q;
    end
    // finished low chunks and pending high operand bits ride along with the beat
    assign {c_n, r} = {1'b0, a_i[k*CHUNK +: CHUNK]} + {1'b0, b_i[k*CHUNK +: CHUNK]}
                      + (CHUNK+1)'(c_i);
    assign unused_bits = ^{a_i, b_i, a_q, b_q};
    always_comb begin
      s_n = s_i;
      s_n[k*CHUNK +: CHUNK] = r;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        c_q <= c_n;
        a_q <= a_i;
        b_q <= b_i;
        s_q <= s_n;
      end
    end
    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (a_i[WIDTH-1] == b_i[WIDTH-1]) && (s_n[WIDTH-1] != a_i[WIDTH-1]);
          zero_q <= s_n == '0;
        end
      end
    end
  end
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum = g_stage[STAGES-1].s_q;
  assign cout = g_stage[STAGES-1].c_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_pipelined_adder_n.sv
// tb_pipelined_adder_n: directed and random checks against an arithmetic reference model
module tb_pipelined_adder_n;
  localparam int W = 16;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a_in, b_in, sum;
  typedef struct {
    int t;
    logic [W-1:0] s;
    logic c;
    logic o;
    logic z;
  } beat_t;
  beat_t q[$];
  int checks = 0;
  int errors = 0;
  int advc = 0;
  logic hold = 1'b0;
  logic [W-1:0] h_sum;
  logic [2:0] h_flags;
  logic obs_valid;
  logic [W-1:0] obs_sum;
  logic [2:0] obs_flags;

  pipelined_adder_n #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // plain integer arithmetic; a beat accepted at advance count t is due when the count reaches t+S
  function automatic beat_t model(input int t, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb);
    beat_t m;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sbv = int'($signed(b));
    int r, sr;
    if (sb) begin
      r = ua - ub - int'(ci);
      sr = sa - sbv - int'(ci);
      m.c = r >= 0;
    end else begin
      r = ua + ub + int'(ci);
      sr = sa + sbv + int'(ci);
      m.c = r > 65535;
    end
    m.t = t;
    m.s = r[W-1:0];
    m.o = sr > 32767 || sr < -32768;
    m.z = m.s == '0;
    return m;
  endfunction

  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sb, input logic ordy, output logic acc);
    logic ev, ea;
    @(negedge clk);
    in_valid = iv;
    a_in = a;
    b_in = b;
    cin = ci;
    sub = sb;
    out_ready = ordy;
    #1;
    ev = q.size() > 0 && q[0].t + S == advc;
    ea = !ev || ordy;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("in_ready", 32'(in_ready), 32'(ea));
    if (ev) begin
      check("sum", 32'(sum), 32'(q[0].s));
      check("cout", 32'(cout), 32'(q[0].c));
      check("ovf", 32'(ovf), 32'(q[0].o));
      check("zero", 32'(zero), 32'(q[0].z));
    end
    if (hold) begin
      check("hold_sum", 32'(sum), 32'(h_sum));
      check("hold_flags", 32'({cout, ovf, zero}), 32'(h_flags));
    end
    hold = ev && !ordy;
    h_sum = sum;
    h_flags = {cout, ovf, zero};
    obs_valid = out_valid;
    obs_sum = sum;
    obs_flags = {cout, ovf, zero};
    if (ev && ordy) void'(q.pop_front());
    acc = iv && ea;
    if (acc) q.push_back(model(advc, a, b, ci, sb));
    if (ea) advc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", 32'({cout, ovf, zero}), 32'd0);
    rst = 1'b0;
    q.delete();
    hold = 1'b0;
    advc = 0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input logic [W-1:0] es,
                          input logic ec, input logic eo, input logic ez);
    logic acc;
    step(1'b1, a, b, ci, sb, 1'b1, acc);
    repeat (S) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check({tag, "_valid"}, 32'(obs_valid), 32'd1);
    check({tag, "_sum"}, 32'(obs_sum), 32'(es));
    check({tag, "_flags"}, 32'(obs_flags), 32'({ec, eo, ez}));
  endtask

  initial begin
    logic acc;
    int idx;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_in = '0;
    b_in = '0;
    cin = 1'b0;
    sub = 1'b0;
    do_reset();
    directed("t1_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("t2_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("t2_cin", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0);
    directed("t3_sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("t3_subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 16'(i * 32'h1111), 1'b0, 1'b0, 1'b1, acc);
    repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      step(idx < 6, 16'(idx * 32'h0123 + 32'h0F00), 16'(idx * 32'h2011), idx[0], idx[1],
           !(c >= 5 && c <= 7), acc);
      if (acc) idx++;
    end
    check("t5_all_accepted", 32'(idx), 32'd6);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(32'h1000 + i), 16'(32'h0100 + i), 1'b0, 1'b0, 1'b1, acc);
    do_reset();
    repeat (8) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    directed("t6_post", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, acc);
    repeat (S + 4) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
